reg_bus_arbiter: RTL
====================

Name: reg_bus_arbiter

Overview:
- Shares the single 8-bit register-write bus of the CPU among NUM_REQ requesters, such as the ALU, memory load path, immediate decoder and I/O.
- Arbitrates round-robin and drives a one-hot register write enable plus the bus data into the bank of generic 8-bit registers.
- Returns a one-cycle grant pulse to the winning requester.
- Sits between the execute-stage sources and the register bank.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_REGS, 8, number of destination registers (power of 2)
DW, 8, bus data width

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
req  input  NUM_REQ  per-requester write request, level
req_addr  input  NUM_REQ*$clog2(NUM_REGS)  destination register index, packed, slot i at [i*AW +: AW]
req_data  input  NUM_REQ*DW  write data, packed, slot i at [i*DW +: DW]
req_lock  input  NUM_REQ  burst lock request (present only with REG_BUS_ARB_LOCK_EN)
gnt  output  NUM_REQ  one-hot grant pulse
reg_wen  output  NUM_REGS  one-hot write enable to the register bank
bus_data  output  DW  data on the register-write bus
busy  output  1  high in any cycle where gnt is non-zero

Behaviour:
- Clocking and reset:
  - Reset is asynchronous, active-high (rst), on clock clk.
  - On reset: gnt=0, reg_wen=0, bus_data=0, busy=0, priority pointer ptr=0, lock owner cleared.
  - Asserting reset mid-transfer kills the registered pulse immediately; no write occurs.
- Registered outputs, latency 1:
  - req, req_addr and req_data are sampled at edge N.
  - The winner w is computed combinationally.
  - Registered during cycle N+1: gnt[w]=1, reg_wen[req_addr[w]]=1, bus_data=req_data[w], busy=1.
  - No request at edge N means all outputs are 0 in cycle N+1; bus_data is driven to 0, not held.
- Round-robin rule:
  - The search starts at index ptr and wraps modulo NUM_REQ; the first eligible req wins.
  - After a grant, ptr = (w+1) mod NUM_REQ. With no grant, ptr is unchanged.
- Eligibility:
  - req[i]=1 and gnt[i]=0 in the current cycle.
  - A requester is never granted on two consecutive cycles, except under a lock.
  - A sole requester holding req continuously is therefore granted every other cycle.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt[i]=1.
  - It may deassert req in the gnt cycle, or keep it high for a further transfer with new addr/data presented that same cycle.
  - Dropping req before grant withdraws the request with no side effect.
- Exactly one bit of reg_wen is set per grant. Addresses are always in range because NUM_REGS is a power of 2.
- Simultaneous requests from all requesters: each is served once in NUM_REQ grants, in rotation order from ptr.
- Outputs are never X after reset. gnt and reg_wen are each either zero or one-hot.

Optional Feature:
- Macro: REG_BUS_ARB_LOCK_EN.
- With the macro defined:
  - The req_lock port exists.
  - If the winner w has req_lock[w]=1 at its grant, it becomes lock owner.
  - While the owner keeps req and req_lock high, it is granted every cycle, bypassing the consecutive-grant exclusion. ptr is frozen and all other requesters are blocked.
  - The lock ends when the owner's req or req_lock is low at a sampling edge. ptr then becomes owner+1 and normal arbitration resumes that same edge.
  - req_lock without req is ignored.
- Without the macro: no req_lock port and no lock state; behaviour is pure round-robin as above.

Decomposition:
- Package cpu_bus_pkg holds:
  - localparams DW=8 and REG_IDX_W=$clog2(NUM_REGS)
  - typedefs data_t (logic [DW-1:0]) and reg_idx_t
  - function onehot_decode(reg_idx_t) returning the reg_wen vector
- One sub-module, rr_pick: a combinational round-robin picker with inputs eligible[NUM_REQ] and ptr, and outputs valid and idx.
- The top level holds ptr, lock state and the output registers.

Test Plan:
- Reset: hold rst with req=4'b1111 → gnt=0, reg_wen=0, bus_data=0, busy=0. Release; first grant goes to req0.
- Single request: req=4'b0100, addr2=3, data2=8'hA5 at edge N → cycle N+1 shows gnt=4'b0100, reg_wen=8'b0000_1000, bus_data=8'hA5. Drop req → outputs 0 next cycle.
- Fairness: all four requesting continuously from ptr=0 → grant order 0,1,2,3,0,1. Each grant carries its own addr/data.
- Consecutive exclusion: req=4'b0001 held high → gnt pulses on alternating cycles (1,0,1,0).
- Mid-transfer reset: assert rst while gnt=4'b0010 → reg_wen drops to 0 asynchronously and ptr returns to 0.
- Lock (macro on): req1 and req_lock1 high for 3 grants while req3 is pending → gnt1 on 3 consecutive cycles. After lock1 drops, gnt3 arrives next and ptr=0 afterwards.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU register-write bus.
package cpu_bus_pkg;

  // Size of the generic register bank the bus normally feeds.
  localparam int unsigned BANK_REGS = 8;
  localparam int unsigned DW        = 8;
  localparam int unsigned REG_IDX_W = $clog2(BANK_REGS);

  typedef logic [DW-1:0]        data_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [BANK_REGS-1:0] reg_wen_t;

  // Register index to one-hot write-enable vector.
  function automatic reg_wen_t onehot_decode(reg_idx_t idx);
    reg_wen_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      idx
);

  logic [PW-1:0] w_cand;

  // Scan NUM_REQ slots starting at ptr; the first hit wins.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_cand = PW'((int'(ptr) + k) % int'(NUM_REQ));
      if (!valid && eligible[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter for the shared register-write bus.
// Registered outputs, one-cycle latency; a requester is never granted on two
// consecutive cycles. Optional burst lock enabled by defining REG_BUS_ARB_LOCK_EN.
module reg_bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned DW       = 8,
  localparam int unsigned AW      = $clog2(NUM_REGS),
  localparam int unsigned PW      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*AW-1:0]  req_addr,
  input  logic [NUM_REQ*DW-1:0]  req_data,
`ifdef REG_BUS_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]     req_lock,
`endif
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REGS-1:0]    reg_wen,
  output logic [DW-1:0]          bus_data,
  output logic                   busy
);

  import cpu_bus_pkg::*;

  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REGS-1:0] r_wen;
  logic [DW-1:0]       r_data;
  logic                r_busy;
  logic [PW-1:0]       r_ptr;

  logic [NUM_REQ-1:0]  w_elig;
  logic                w_pick_valid;
  logic [PW-1:0]       w_pick_idx;
  logic                w_win_valid;
  logic [PW-1:0]       w_win;
  logic                w_hold;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_data;
  logic [NUM_REGS-1:0] w_wen;
  logic [NUM_REQ-1:0]  w_gnt_d;
  logic [PW-1:0]       w_ptr_d;

`ifdef REG_BUS_ARB_LOCK_EN
  logic                r_lock_act;
  logic [PW-1:0]       r_lock_own;
  logic                w_lock_act_d;
  logic [PW-1:0]       w_lock_own_d;
`endif

  // Eligibility: requesting and not granted this cycle; lock hold when the owner keeps both levels.
  always_comb begin
    w_elig = req & ~r_gnt;
`ifdef REG_BUS_ARB_LOCK_EN
    w_hold = r_lock_act & req[r_lock_own] & req_lock[r_lock_own];
`else
    w_hold = 1'b0;
`endif
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .eligible (w_elig),
    .ptr      (r_ptr),
    .valid    (w_pick_valid),
    .idx      (w_pick_idx)
  );

  // Winner selection, bus mux and pointer advance.
  always_comb begin
    w_win_valid = w_pick_valid;
    w_win       = w_pick_idx;
`ifdef REG_BUS_ARB_LOCK_EN
    if (w_hold) begin
      w_win_valid = 1'b1;
      w_win       = r_lock_own;
    end
`endif
    w_addr  = req_addr[w_win*AW +: AW];
    w_data  = req_data[w_win*DW +: DW];
    w_gnt_d = '0;
    if (w_win_valid) begin
      w_gnt_d[w_win] = 1'b1;
    end
    // Pointer is frozen while a lock is held; on lock start it already sits at owner+1.
    w_ptr_d = r_ptr;
    if (w_win_valid && !w_hold) begin
      w_ptr_d = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end
  end

  // Address decode: use the bank helper when the bank matches its size.
  if (NUM_REGS == BANK_REGS) begin : g_pkg_dec
    assign w_wen = onehot_decode(reg_idx_t'(w_addr));
  end else begin : g_shift_dec
    assign w_wen = NUM_REGS'(1) << w_addr;
  end

  // Output and pointer registers; async reset kills any in-flight pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt  <= '0;
      r_wen  <= '0;
      r_data <= '0;
      r_busy <= 1'b0;
      r_ptr  <= '0;
    end else begin
      r_gnt  <= w_gnt_d;
      r_wen  <= w_win_valid ? w_wen : '0;
      r_data <= w_win_valid ? w_data : '0;
      r_busy <= w_win_valid;
      r_ptr  <= w_ptr_d;
    end
  end

`ifdef REG_BUS_ARB_LOCK_EN
  // Lock next state: held while owner keeps req+lock, else taken by a locking winner.
  always_comb begin
    w_lock_act_d = 1'b0;
    w_lock_own_d = r_lock_own;
    if (w_hold) begin
      w_lock_act_d = 1'b1;
    end else if (w_pick_valid && req_lock[w_pick_idx]) begin
      w_lock_act_d = 1'b1;
      w_lock_own_d = w_pick_idx;
    end
  end

  // Lock owner register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_act <= 1'b0;
      r_lock_own <= '0;
    end else begin
      r_lock_act <= w_lock_act_d;
      r_lock_own <= w_lock_own_d;
    end
  end
`endif

  assign gnt      = r_gnt;
  assign reg_wen  = r_wen;
  assign bus_data = r_data;
  assign busy     = r_busy;

endmodule
